// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM states,
// operation encodings and the default operand width.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic OP_MULT   = 1'b0;
    localparam logic OP_DIV    = 1'b1;
    localparam int   WIDTH_DEF = 32;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the issuing pipeline (master) and the
// multiply/divide unit (slave).
interface muldiv_seq_if
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb,
        input  busy, done, divzero, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb,
        output busy, done, divzero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// MULT: acc holds the running upper product, mq the multiplier being shifted
//       out (its freed MSBs collect product low bits), opnd the multiplicand.
// DIV:  acc holds the partial remainder, mq the dividend being shifted out
//       (its freed LSBs collect quotient bits), opnd the divisor.
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mq,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_mq
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Compute the next accumulator/shift-register pair for a single step.
    always_comb begin
        w_sum   = {1'b0, i_acc} + {1'b0, i_opnd};
        w_shift = {i_acc, i_mq[WIDTH-1]};
        // Remainder stays below the divisor, so a borrow shows up in bit WIDTH.
        w_diff  = w_shift - {1'b0, i_opnd};
        if (i_op == OP_MULT) begin
            if (i_mq[0]) begin
                o_acc = w_sum[WIDTH:1];
                o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
            end else begin
                o_acc = {1'b0, i_acc[WIDTH-1:1]};
                o_mq  = {i_acc[0], i_mq[WIDTH-1:1]};
            end
        end else begin
            if (!w_diff[WIDTH]) begin
                o_acc = w_diff[WIDTH-1:0];
                o_mq  = {i_mq[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shift[WIDTH-1:0];
                o_mq  = {i_mq[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed multiply/divide unit (MIPS-style HI/LO). Operands are
// converted to magnitudes on acceptance, WIDTH unsigned iterations run, and a
// final FIX cycle applies the sign correction and writes hi/lo.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    localparam int                 CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE2     = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_opnd;
    logic             r_busy;
    logic             r_done;
    logic             r_divzero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_mq;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        w_sa    = bus.srca[WIDTH-1];
        w_sb    = bus.srcb[WIDTH-1];
        w_a_abs = w_sa ? (~bus.srca + ONE) : bus.srca;
        w_b_abs = w_sb ? (~bus.srcb + ONE) : bus.srcb;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_mq   (r_mq),
        .i_opnd (r_opnd),
        .o_acc  (w_step_acc),
        .o_mq   (w_step_mq)
    );

    // Sign correction of the finished unsigned result; divide-by-zero bypasses it.
    always_comb begin
        w_prod     = {r_acc, r_mq};
        w_prod_neg = ~w_prod + ONE2;
        if (r_dz) begin
            w_fix_hi = r_acc;
            w_fix_lo = r_mq;
        end else if (r_op == OP_MULT) begin
            {w_fix_hi, w_fix_lo} = r_neg_q ? w_prod_neg : w_prod;
        end else begin
            w_fix_lo = r_neg_q ? (~r_mq + ONE) : r_mq;
            w_fix_hi = r_neg_r ? (~r_acc + ONE) : r_acc;
        end
    end

    // Control FSM, iteration datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_op      <= OP_MULT;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_opnd    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op      <= bus.op;
                        r_neg_q   <= w_sa ^ w_sb;
                        r_neg_r   <= w_sa;
                        r_cnt     <= '0;
                        r_divzero <= 1'b0;
                        r_busy    <= 1'b1;
                        r_acc     <= '0;
                        if ((bus.op == OP_DIV) && (bus.srcb == '0)) begin
                            // Stage the fixed divide-by-zero result directly.
                            r_dz    <= 1'b1;
                            r_acc   <= bus.srca;
                            r_mq    <= '1;
                            r_state <= FIX;
                        end else if (bus.op == OP_MULT) begin
                            r_dz    <= 1'b0;
                            r_mq    <= w_b_abs;
                            r_opnd  <= w_a_abs;
                            r_state <= RUN;
                        end else begin
                            r_dz    <= 1'b0;
                            r_mq    <= w_a_abs;
                            r_opnd  <= w_b_abs;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_step_acc;
                    r_mq  <= w_step_mq;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_hi      <= w_fix_hi;
                    r_lo      <= w_fix_lo;
                    r_divzero <= r_dz;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.divzero = r_divzero;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
endmodule
